counter_updown_32: RTL and testbench

//  Programmable up/down counter driven by the enable/modo/para stimulus interface.

---
 rtl/counter_updown_32_pkg.sv | 38 +++
 rtl/counter_updown_32_next.sv | 30 +++
 rtl/counter_updown_32.sv | 107 ++++++++++
 tb/tb_counter_updown_32.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/counter_updown_32_pkg.sv
// Shared definitions for the up/down counter:
// command modes, debug state codes, widths.
package counter_updown_32_pkg;

  localparam int WIDTH  = 32;
  localparam int WRAP_W = 16;

  typedef enum logic [1:0] {
    MODE_UP   = 2'd0,
    MODE_DN1  = 2'd1,
    MODE_DN3  = 2'd2,
    MODE_LOAD = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_UP    = 3'd1,
    ST_DOWN  = 3'd2,
    ST_DOWN3 = 3'd3,
    ST_LOAD  = 3'd4
  } state_e;

  // Debug state reached after executing mode m.
  function automatic state_e mode_to_state(
    input mode_e m
  );
    state_e s;
    s = ST_IDLE;
    unique case (m)
      MODE_UP:   s = ST_UP;
      MODE_DN1:  s = ST_DOWN;
      MODE_DN3:  s = ST_DOWN3;
      MODE_LOAD: s = ST_LOAD;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/counter_updown_32_next.sv
// Combinational next-count datapath:
// one extra bit carries the carry/borrow out.
module counter_updown_32_next
  import counter_updown_32_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] q_i,
  input  mode_e        modo_i,
  input  logic [W-1:0] para_i,
  output logic [W-1:0] next_q_o,
  output logic         carry_o
);

  logic [W:0] sum;

  // Widened add/sub; bit W is carry (up) or borrow (down).
  always_comb begin
    sum = '0;
    unique case (modo_i)
      MODE_UP:   sum = {1'b0, q_i} + (W+1)'(1);
      MODE_DN1:  sum = {1'b0, q_i} - (W+1)'(1);
      MODE_DN3:  sum = {1'b0, q_i} - (W+1)'(3);
      MODE_LOAD: sum = {1'b0, para_i};
    endcase
    next_q_o = sum[W-1:0];
    carry_o  = sum[W];
  end

endmodule

// File: rtl/counter_updown_32.sv
// Programmable up/down counter with carry pulse,
// load acknowledge, saturating wrap count, debug FSM.
module counter_updown_32
  import counter_updown_32_pkg::*;
#(
  parameter int WIDTH  = counter_updown_32_pkg::WIDTH,
  parameter int WRAP_W = counter_updown_32_pkg::WRAP_W
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              enable,
  input  logic [1:0]        modo,
  input  logic [WIDTH-1:0]  para,
  output logic [WIDTH-1:0]  q,
  output logic              rco,
  output logic              load_ack,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [2:0]        state
);

  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

  mode_e             mode;
  logic [WIDTH-1:0]  nxt_q;
  logic              nxt_c;

  logic [WIDTH-1:0]  q_q, q_d;
  logic              rco_q, rco_d;
  logic              ack_q, ack_d;
  logic [WRAP_W-1:0] wrap_q, wrap_d;
  state_e            st_q, st_d;

  assign mode = mode_e'(modo);

  counter_updown_32_next #(
    .W (WIDTH)
  ) u_next (
    .q_i      (q_q),
    .modo_i   (mode),
    .para_i   (para),
    .next_q_o (nxt_q),
    .carry_o  (nxt_c)
  );

  // Datapath next values; disabled cycles hold count, drop pulses.
  always_comb begin
    q_d   = q_q;
    rco_d = 1'b0;
    ack_d = 1'b0;
    if (enable) begin
      q_d   = nxt_q;
      rco_d = nxt_c;
      ack_d = (mode == MODE_LOAD);
    end
  end

  // Wrap counter counts rco pulses and sticks at all-ones.
  always_comb begin
    wrap_d = wrap_q;
    if (rco_d && (wrap_q != WRAP_MAX)) begin
      wrap_d = wrap_q + WRAP_W'(1);
    end
  end

  // Datapath registers, reset wins over any command.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      q_q    <= '0;
      rco_q  <= 1'b0;
      ack_q  <= 1'b0;
      wrap_q <= '0;
    end else begin
      q_q    <= q_d;
      rco_q  <= rco_d;
      ack_q  <= ack_d;
      wrap_q <= wrap_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      st_q <= ST_IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  // FSM next state: any state, incl. illegal codes, follows modo.
  always_comb begin
    st_d = st_q;
    if (enable) begin
      st_d = mode_to_state(mode);
    end
  end

  // FSM output: expose the last executed mode.
  always_comb begin
    state = st_q;
  end

  assign q        = q_q;
  assign rco      = rco_q;
  assign load_ack = ack_q;
  assign wrap_cnt = wrap_q;

endmodule

// File: tb/tb_counter_updown_32.sv
// Scoreboard bench for counter_updown_32:
// driver queues expectations, monitor pops and compares.
module tb_counter_updown_32;

  typedef struct {
    logic [31:0] q;
    logic        rco;
    logic        ack;
    logic [15:0] wrap;
    logic [2:0]  st;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_L;
  logic        enable;
  logic [1:0]  modo;
  logic [31:0] para;
  logic [31:0] q;
  logic        rco;
  logic        load_ack;
  logic [15:0] wrap_cnt;
  logic [2:0]  state;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  counter_updown_32 dut (
    .clk      (clk),
    .reset_L  (reset_L),
    .enable   (enable),
    .modo     (modo),
    .para     (para),
    .q        (q),
    .rco      (rco),
    .load_ack (load_ack),
    .wrap_cnt (wrap_cnt),
    .state    (state)
  );

  task automatic step(
    input logic        r,
    input logic        en,
    input logic [1:0]  m,
    input logic [31:0] p,
    input logic [31:0] eq,
    input logic        erco,
    input logic        eack,
    input logic [15:0] ew,
    input logic [2:0]  es,
    input string       nm
  );
    exp_t e;
    @(negedge clk);
    reset_L = r;
    enable  = en;
    modo    = m;
    para    = p;
    @(posedge clk);
    e.q = eq; e.rco = erco; e.ack = eack;
    e.wrap = ew; e.st = es; e.name = nm;
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_tests++;
      if (q !== e.q) begin
        n_fail++;
        $display("FAIL %s q: got %h exp %h", e.name, q, e.q);
      end
      n_tests++;
      if (rco !== e.rco) begin
        n_fail++;
        $display("FAIL %s rco: got %b exp %b", e.name, rco, e.rco);
      end
      n_tests++;
      if (load_ack !== e.ack) begin
        n_fail++;
        $display("FAIL %s load_ack: got %b exp %b",
                 e.name, load_ack, e.ack);
      end
      n_tests++;
      if (wrap_cnt !== e.wrap) begin
        n_fail++;
        $display("FAIL %s wrap_cnt: got %0d exp %0d",
                 e.name, wrap_cnt, e.wrap);
      end
      n_tests++;
      if (state !== e.st) begin
        n_fail++;
        $display("FAIL %s state: got %0d exp %0d", e.name, state, e.st);
      end
    end
  end

  initial begin
    logic [32:0] big;
    big = 33'h1_0000_0000;
    reset_L = 1'b0;
    enable  = 1'b1;
    modo    = 2'd0;
    para    = '0;

    // reset with an active up command
    step(0, 1, 0, 0, 32'd0, 0, 0, 0, 0, "rst1");
    step(0, 1, 0, 0, 32'd0, 0, 0, 0, 0, "rst2");

    // up wrap at all-ones
    step(1, 1, 3, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 0, 1, 0, 4, "ld_fe");
    step(1, 1, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, "up_ff");
    step(1, 1, 0, 0, 32'h0000_0000, 1, 0, 1, 1, "up_wrap");
    step(1, 1, 0, 0, 32'h0000_0001, 0, 0, 1, 1, "up_one");

    // down 3 with borrow
    step(1, 1, 3, 32'd2, 32'd2, 0, 1, 1, 4, "ld_2");
    step(1, 1, 2, 0, 32'hFFFF_FFFF, 1, 0, 2, 3, "dn3_bor");
    step(1, 1, 2, 0, 32'hFFFF_FFFC, 0, 0, 2, 3, "dn3_nob");

    // down 1 borrow, then back-to-back loads
    step(1, 1, 3, 32'd0, 32'd0, 0, 1, 2, 4, "ld_0");
    step(1, 1, 1, 0, 32'hFFFF_FFFF, 1, 0, 3, 2, "dn1_bor");
    step(1, 1, 3, 32'd0, 32'd0, 0, 1, 3, 4, "ld_b2b1");
    step(1, 1, 3, 32'd1, 32'd1, 0, 1, 3, 4, "ld_b2b2");

    // hold
    step(1, 1, 3, 32'd700, 32'd700, 0, 1, 3, 4, "ld_700");
    step(1, 0, 1, 0, 32'd700, 0, 0, 3, 4, "hold1");
    step(1, 0, 1, 0, 32'd700, 0, 0, 3, 4, "hold2");
    step(1, 0, 1, 0, 32'd700, 0, 0, 3, 4, "hold3");
    step(1, 1, 1, 0, 32'd699, 0, 0, 3, 2, "dn1_699");

    // load and truncated load
    step(1, 1, 3, 32'd5000000, 32'd5000000, 0, 1, 3, 4, "ld_5m");
    step(1, 1, 3, big[31:0], 32'd0, 0, 1, 3, 4, "ld_trunc");

    // reset mid-run
    step(1, 1, 3, 32'd100, 32'd100, 0, 1, 3, 4, "ld_100");
    step(1, 1, 0, 0, 32'd101, 0, 0, 3, 1, "up_101");
    step(1, 1, 0, 0, 32'd102, 0, 0, 3, 1, "up_102");
    step(0, 1, 0, 0, 32'd0, 0, 0, 0, 0, "rst_mid");
    step(1, 1, 0, 0, 32'd1, 0, 0, 0, 1, "resume1");
    step(1, 1, 0, 0, 32'd2, 0, 0, 0, 1, "resume2");

    // down 3 boundary: 3 -> 0 no borrow, 0 -> -3 borrow
    step(1, 1, 3, 32'd3, 32'd3, 0, 1, 0, 4, "ld_3");
    step(1, 1, 2, 0, 32'd0, 0, 0, 0, 3, "dn3_3");
    step(1, 1, 2, 0, 32'hFFFF_FFFD, 1, 0, 1, 3, "dn3_0");
    step(1, 0, 0, 0, 32'hFFFF_FFFD, 0, 0, 1, 3, "idle");

    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(posedge clk);
    end
    #2;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d left, exp 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
